// File: rtl/bcd2bin_seq.sv
// Sequential packed-BCD to binary converter (reverse double-dabble, one bit per clock).
// Latency: done pulses WIDTH+2 clocks after start is accepted (2 clocks if a nibble is > 9).
// Backpressure: start is only sampled in IDLE; requests made while busy are dropped.
module bcd2bin_seq #(
  parameter int NDIG  = 8,
  parameter int WIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [4*NDIG-1:0] bcd_in,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [WIDTH-1:0]  value
);

  localparam int BW = 4 * NDIG;
  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SHIFT  = 2'd1;
  localparam logic [1:0] FINISH = 2'd2;

  logic [1:0]       state;
  logic [BW-1:0]    bcd_r;
  logic [BW-1:0]    bcd_nxt;
  logic [WIDTH-1:0] bin_r;
  logic [WIDTH-1:0] bin_nxt;
  logic [CW-1:0]    cnt;
  logic             bad;
  logic             in_bad;

  // Flag an operand that holds any non-decimal nibble; such operands skip the shift loop.
  always_comb begin
    in_bad = 1'b0;
    for (int i = 0; i < NDIG; i++) begin
      if (bcd_in[4*i +: 4] > 4'd9) in_bad = 1'b1;
    end
  end

  // One reverse double-dabble step: shift {bcd,bin} right, then correct every nibble >= 8 by -3.
  always_comb begin
    bin_nxt = {bcd_r[0], bin_r[WIDTH-1:1]};
    bcd_nxt = {1'b0, bcd_r[BW-1:1]};
    for (int i = 0; i < NDIG; i++) begin
      if (bcd_nxt[4*i +: 4] >= 4'd8) bcd_nxt[4*i +: 4] = bcd_nxt[4*i +: 4] - 4'd3;
    end
  end

  // Control FSM and datapath registers; value/err only change in FINISH so they hold across a conversion.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      bcd_r <= '0;
      bin_r <= '0;
      cnt   <= '0;
      bad   <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
      value <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            bcd_r <= bcd_in;
            bin_r <= '0;
            cnt   <= CW'(WIDTH - 1);
            busy  <= 1'b1;
            bad   <= in_bad;
            state <= in_bad ? FINISH : SHIFT;
          end
        end
        SHIFT: begin
          bcd_r <= bcd_nxt;
          bin_r <= bin_nxt;
          if (cnt == '0) state <= FINISH;
          else           cnt   <= cnt - 1'b1;
        end
        FINISH: begin
          value <= bad ? '0 : bin_r;
          err   <= bad;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
